mem_port_arbiter: RTL and testbench

Shares the single-port unified memory between the instruction-fetch (IF) and data-memory (MEM-stage) ports of the 5-stage RV32I pipeline. It arbitrates requests, latches the winning request onto the memory bus, waits a variable number of cycles for `mem_ready`, returns the read data with a one-cycle ack, and raises `stall` to the pipeline controller while any request is unserved. Data accesses have priority, and a starvation limit guarantees fetch progress.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/mem_arb_starve_cnt.sv | 27 ++
 rtl/mem_port_arbiter.sv | 91 +++++++++
 tb/tb_mem_port_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared RV32I core package: arbiter state, bus-request record and starvation defaults.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    IF_BUSY,
    DM_BUSY
  } arb_state_t;

  localparam int ARB_STARVE_LIMIT_DEFAULT = 4;
  localparam int ARB_STARVE_W             = 3;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  w_en;
    logic [31:0] wdata;
  } mem_bus_t;

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Saturating count of consecutive data grants taken while a fetch was waiting.
module mem_arb_starve_cnt
  import cpu_pkg::*;
#(
  parameter int LIMIT = ARB_STARVE_LIMIT_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    inc,
  input  logic                    clr,
  output logic [ARB_STARVE_W-1:0] cnt,
  output logic                    hit
);

  localparam logic [ARB_STARVE_W-1:0] CNT_MAX = '1;
  // One extra bit so a LIMIT beyond the counter range simply never hits.
  localparam logic [ARB_STARVE_W:0]   LIM     = (ARB_STARVE_W+1)'(LIMIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                     cnt <= '0;
    else if (clr)                 cnt <= '0;
    else if (inc && cnt != CNT_MAX) cnt <= cnt + 1'b1;
  end

  assign hit = {1'b0, cnt} >= LIM;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data accesses; data wins unless fetch is starved.
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int STARVE_LIMIT = ARB_STARVE_LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        dm_req,
  input  logic [3:0]  dm_w_en,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ack,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_w_en,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        stall
);

  arb_state_t               state;
  mem_bus_t                 bus;
  logic [ARB_STARVE_W-1:0]  starve_cnt;
  logic                     starve_hit;
  logic                     dm_grant;
  logic                     if_grant;

  assign dm_grant = (state == IDLE) && dm_req && !(if_req && starve_hit);
  assign if_grant = (state == IDLE) && if_req && !dm_grant;

  mem_arb_starve_cnt #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk (clk),
    .rst (rst),
    .inc (dm_grant && if_req),
    .clr (if_grant || !if_req),
    .cnt (starve_cnt),
    .hit (starve_hit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      mem_req <= 1'b0;
      bus     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dm_grant) begin
            state   <= DM_BUSY;
            mem_req <= 1'b1;
            bus     <= '{addr: dm_addr, w_en: dm_w_en, wdata: dm_wdata};
          end else if (if_grant) begin
            state   <= IF_BUSY;
            mem_req <= 1'b1;
            bus     <= '{addr: if_addr, w_en: 4'h0, wdata: 32'h0};
          end
        end
        IF_BUSY, DM_BUSY: begin
          // Completes even if the owner dropped its request; ack below is then masked.
          if (mem_ready) begin
            state   <= IDLE;
            mem_req <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign mem_addr  = bus.addr;
  assign mem_w_en  = bus.w_en;
  assign mem_wdata = bus.wdata;

  assign if_ack   = (state == IF_BUSY) && mem_ready && if_req;
  assign dm_ack   = (state == DM_BUSY) && mem_ready && dm_req;
  assign if_rdata = if_ack ? mem_rdata : 32'h0;
  assign dm_rdata = dm_ack ? mem_rdata : 32'h0;

  assign stall = (if_req && !if_ack) || (dm_req && !dm_ack);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus random traffic against a port-ownership reference model.
module tb_mem_port_arbiter;

  localparam int STARVE = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dm_req, mem_ready;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [3:0]  dm_w_en;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_ack, dm_ack, mem_req, stall;
  logic [3:0]  mem_w_en;

  int errs   = 0;
  int checks = 0;

  mem_port_arbiter #(.STARVE_LIMIT(STARVE)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_w_en(dm_w_en), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_w_en(mem_w_en), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      if (errs <= 40) $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: who owns the bus (0 none, 1 fetch, 2 data), what it latched, and
  // how many data grants in a row a waiting fetch has sat through.
  int          m_port, m_scnt;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_wen;
  logic        l_if_ack, l_dm_ack;

  task automatic model_reset();
    m_port = 0; m_scnt = 0; m_addr = 0; m_wdata = 0; m_wen = 0;
    l_if_ack = 0; l_dm_ack = 0;
  endtask

  task automatic model_check();
    logic e_ifa, e_dma;
    e_ifa = (m_port == 1) && mem_ready && if_req;
    e_dma = (m_port == 2) && mem_ready && dm_req;
    check("mem_req",    mem_req,    m_port != 0);
    check("mem_addr",   mem_addr,   m_addr);
    check("mem_w_en",   mem_w_en,   m_wen);
    check("mem_wdata",  mem_wdata,  m_wdata);
    check("starve_cnt", dut.starve_cnt, 32'(m_scnt));
    check("if_ack",     if_ack,     e_ifa);
    check("if_rdata",   if_rdata,   e_ifa ? mem_rdata : 32'h0);
    check("dm_ack",     dm_ack,     e_dma);
    check("dm_rdata",   dm_rdata,   e_dma ? mem_rdata : 32'h0);
    check("stall",      stall,      (if_req && !e_ifa) || (dm_req && !e_dma));
    l_if_ack = e_ifa;
    l_dm_ack = e_dma;
  endtask

  task automatic model_advance();
    if (m_port == 0) begin
      if (dm_req && !(if_req && m_scnt >= STARVE)) begin
        m_port = 2; m_addr = dm_addr; m_wen = dm_w_en; m_wdata = dm_wdata;
        if (if_req && m_scnt < 7) m_scnt++;
      end else if (if_req) begin
        m_port = 1; m_addr = if_addr; m_wen = 0; m_wdata = 0;
        m_scnt = 0;
      end
    end else if (mem_ready) begin
      m_port = 0;
    end
    if (!if_req) m_scnt = 0;
  endtask

  task automatic step(input logic ifr, input logic [31:0] ia, input logic dr,
                      input logic [3:0] dw, input logic [31:0] da, input logic [31:0] dd,
                      input logic rdy, input logic [31:0] rd);
    @(negedge clk);
    if_req = ifr; if_addr = ia; dm_req = dr; dm_w_en = dw; dm_addr = da; dm_wdata = dd;
    mem_ready = rdy; mem_rdata = rd;
    #1;
    model_check();
    model_advance();
  endtask

  task automatic do_reset(input logic dr, input logic rdy);
    @(negedge clk);
    dm_req = dr; mem_ready = rdy; if_req = 1'b0;
    rst = 1'b0;
    #1;
    check("rst_mem_req", mem_req, 0);
    check("rst_dm_ack",  dm_ack, 0);
    check("rst_dm_rdata", dm_rdata, 0);
    check("rst_starve",  dut.starve_cnt, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_stall",   stall, dr);
    model_reset();
    @(negedge clk);
    dm_req = 1'b0;
    rst = 1'b1;
  endtask

  initial begin
    logic        ir, dr, rdy;
    logic [31:0] ia, da, dd, rd;
    logic [3:0]  dw;
    int          ndm;
    logic        seen_if;

    rst = 1'b0;
    if_req = 1'b1; if_addr = 32'h44; dm_req = 1'b0; dm_w_en = 0; dm_addr = 0; dm_wdata = 0;
    mem_ready = 1'b1; mem_rdata = 32'hA5A5A5A5;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("reset_mem_req",   mem_req, 0);
    check("reset_mem_addr",  mem_addr, 0);
    check("reset_mem_w_en",  mem_w_en, 0);
    check("reset_mem_wdata", mem_wdata, 0);
    check("reset_if_ack",    if_ack, 0);
    check("reset_if_rdata",  if_rdata, 0);
    check("reset_dm_ack",    dm_ack, 0);
    check("reset_stall",     stall, 1);
    @(negedge clk);
    if_req = 1'b0;
    rst = 1'b1;

    // Fetch only, single-cycle memory.
    step(1, 32'h40, 0, 0, 0, 0, 1, 32'h1111_2222);
    check("f_stall0",  stall, 1);
    check("f_mreq0",   mem_req, 0);
    step(1, 32'h40, 0, 0, 0, 0, 1, 32'h3333_4444);
    check("f_mreq1",   mem_req, 1);
    check("f_addr1",   mem_addr, 32'h40);
    check("f_ack1",    if_ack, 1);
    check("f_rdata1",  if_rdata, 32'h3333_4444);
    check("f_stall1",  stall, 0);
    step(0, 0, 0, 0, 0, 0, 1, 32'h5);
    check("f_mreq2",   mem_req, 0);

    // Store with three wait states; bus stays latched even when inputs move.
    step(0, 0, 1, 4'hF, 32'h100, 32'hDEADBEEF, 0, 0);
    ndm = 0;
    for (int c = 1; c <= 3; c++) begin
      step(0, 0, 1, 4'hF, (c == 2) ? 32'h200 : 32'h100, 32'hDEADBEEF, 0, 32'h77);
      check("st_addr",  mem_addr, 32'h100);
      check("st_wen",   mem_w_en, 4'hF);
      check("st_wdata", mem_wdata, 32'hDEADBEEF);
      ndm += dm_ack;
    end
    step(0, 0, 1, 4'hF, 32'h100, 32'hDEADBEEF, 1, 32'h99);
    check("st_ack", dm_ack, 1);
    ndm += dm_ack;
    check("st_ack_count", ndm, 1);
    step(0, 0, 0, 0, 0, 0, 1, 0);

    // Simultaneous requests: data first, fetch after the idle cycle.
    step(1, 32'h80, 1, 4'h0, 32'h300, 0, 1, 32'h10);
    step(1, 32'h80, 1, 4'h0, 32'h300, 0, 1, 32'h11);
    check("sim_dm_ack1", dm_ack, 1);
    check("sim_if_ack1", if_ack, 0);
    check("sim_stall1",  stall, 1);
    step(1, 32'h80, 0, 0, 0, 0, 1, 32'h12);
    check("sim_mreq2",   mem_req, 0);
    check("sim_stall2",  stall, 1);
    step(1, 32'h80, 0, 0, 0, 0, 1, 32'h13);
    check("sim_if_ack3", if_ack, 1);
    check("sim_addr3",   mem_addr, 32'h80);
    step(0, 0, 0, 0, 0, 0, 1, 0);

    // Starvation: continuous data traffic must let the fetch in after 4 grants.
    ndm = 0; seen_if = 1'b0;
    for (int c = 0; c < 14 && !seen_if; c++) begin
      step(1, 32'hC0, 1, 4'h3, 32'h400 + 32'(c), 32'(c), 1, 32'(c));
      if (if_ack) begin
        seen_if = 1'b1;
        check("starve_clr", dut.starve_cnt, 0);
      end else begin
        ndm += dm_ack;
      end
    end
    check("starve_seen_if", seen_if, 1);
    check("starve_dm_grants", ndm, STARVE);
    step(0, 0, 0, 0, 0, 0, 1, 0);

    // Reset in the middle of a data access.
    step(1, 32'h500, 1, 4'h1, 32'h600, 32'h1, 0, 0);
    step(1, 32'h500, 1, 4'h1, 32'h600, 32'h1, 0, 0);
    check("mr_busy", mem_req, 1);
    do_reset(1, 1);
    for (int c = 0; c < 3; c++) begin
      step(0, 0, 0, 0, 0, 0, 1, 32'hF);
      check("mr_idle", mem_req, 0);
    end

    // Fetch request withdrawn while on the bus.
    step(1, 32'h700, 0, 0, 0, 0, 0, 0);
    step(0, 32'h700, 0, 0, 0, 0, 0, 0);
    check("drop_busy", mem_req, 1);
    step(0, 32'h700, 0, 0, 0, 0, 1, 32'h21);
    check("drop_ack",   if_ack, 0);
    check("drop_stall", stall, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    check("drop_idle", mem_req, 0);

    // Random traffic; requests held until acked, with rare protocol drops.
    ir = 0; dr = 0; ia = 0; da = 0; dd = 0; dw = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!ir || l_if_ack) begin
        ir = ($urandom_range(0, 99) < 60);
        ia = $urandom;
      end else if ($urandom_range(0, 99) < 2) begin
        ir = 1'b0;
      end
      if (!dr || l_dm_ack) begin
        dr = ($urandom_range(0, 99) < 70);
        da = $urandom;
        dd = $urandom;
        dw = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
      end else if ($urandom_range(0, 99) < 2) begin
        dr = 1'b0;
      end
      rdy = ($urandom_range(0, 99) < 50);
      rd  = $urandom;
      step(ir, ia, dr, dw, da, dd, rdy, rd);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
